prefetch_sequencer: RTL and testbench



---
 rtl/prefetch_sequencer.sv | 162 ++++++++++++++++
 tb/tb_prefetch_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_sequencer.sv
// Purpose: instruction prefetch sequencer; issues word fetches from CS:IP into a byte FIFO and flushes it on CS:IP updates.
// Latency: a request starts the cycle after the FSM leaves IDLE; acked bytes are visible at the FIFO head the next cycle.
// Backpressure: no fetch starts unless the FIFO has room for the whole fetch; the decoder pops with fifo_rd_en.
// Optional: define PREFETCH_FLUSH_COUNT_EN to add the flush_count output.
module prefetch_sequencer #(
  parameter int FIFO_DEPTH = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cs,
  input  logic [15:0] new_ip,
  input  logic        load_new_ip,
  output logic        mem_access,
  output logic [18:0] mem_address,
  output logic [1:0]  mem_bytesel,
  input  logic [15:0] mem_data,
  input  logic        mem_ack,
  input  logic        fifo_rd_en,
  output logic [7:0]  fifo_rd_data,
  output logic        fifo_empty
`ifdef PREFETCH_FLUSH_COUNT_EN
  ,
  output logic [15:0] flush_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FETCH      = 2'd1,
    S_FLUSH_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [15:0]     r_fetch_ip;
  logic [18:0]     r_mem_address;
  logic [1:0]      r_mem_bytesel;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_mem_access;
  logic [CW-1:0]   w_free;
  logic            w_room;
  logic [19:0]     w_phys;
  logic            w_start;
  logic            w_ack_take;
  logic            w_push_one;
  logic            w_push_two;
  logic            w_pop;
  logic [PW-1:0]   w_wr_ptr_p1;

  // Pointer increment with wrap at FIFO_DEPTH (depth need not be a power of two).
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // An even fetch lands two bytes, an odd fetch only the high byte.
  assign w_free      = CW'(FIFO_DEPTH) - r_count;
  assign w_room      = r_fetch_ip[0] ? (w_free >= CW'(1)) : (w_free >= CW'(2));
  // Segment base plus offset, wrapping in the 20-bit physical space.
  assign w_phys      = {cs, 4'b0000} + {4'b0000, r_fetch_ip};
  assign w_start     = (r_state == S_IDLE) && w_room && !load_new_ip;
  // Data coinciding with a CS:IP update belongs to the old stream and is dropped.
  assign w_ack_take  = (r_state == S_FETCH) && mem_ack && !load_new_ip;
  assign w_push_two  = w_ack_take && !r_fetch_ip[0];
  assign w_push_one  = w_ack_take && r_fetch_ip[0];
  assign w_pop       = fifo_rd_en && !fifo_empty && !load_new_ip;
  assign w_wr_ptr_p1 = f_inc(r_wr_ptr);

  assign mem_access   = w_mem_access;
  assign mem_address  = r_mem_address;
  assign mem_bytesel  = r_mem_bytesel;
  assign fifo_empty   = (r_count == '0);
  assign fifo_rd_data = fifo_empty ? 8'h00 : r_mem[r_rd_ptr];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state and bus request; an outstanding access always runs to its ack.
  always_comb begin
    w_next_state = r_state;
    w_mem_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        w_mem_access = 1'b1;
        if (mem_ack)          w_next_state = S_IDLE;
        else if (load_new_ip) w_next_state = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        w_mem_access = 1'b1;
        if (mem_ack) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Fetch pointer: reload on CS:IP update, advance by the bytes actually taken.
  always_ff @(posedge clk) begin
    if (reset)            r_fetch_ip <= 16'h0000;
    else if (load_new_ip) r_fetch_ip <= new_ip;
    else if (w_push_two)  r_fetch_ip <= r_fetch_ip + 16'd2;
    else if (w_push_one)  r_fetch_ip <= r_fetch_ip + 16'd1;
  end

  // Address and byte enables are captured at request start and held until the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_address <= '0;
      r_mem_bytesel <= 2'b00;
    end else if (w_start) begin
      r_mem_address <= w_phys[19:1];
      r_mem_bytesel <= r_fetch_ip[0] ? 2'b10 : 2'b11;
    end
  end

  // FIFO storage writes; low byte first for an even fetch.
  always_ff @(posedge clk) begin
    if (w_push_two) begin
      r_mem[r_wr_ptr]    <= mem_data[7:0];
      r_mem[w_wr_ptr_p1] <= mem_data[15:8];
    end else if (w_push_one) begin
      r_mem[r_wr_ptr] <= mem_data[15:8];
    end
  end

  // FIFO pointers and occupancy; a CS:IP update empties the FIFO at the next edge.
  always_ff @(posedge clk) begin
    if (reset || load_new_ip) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_two)      r_wr_ptr <= f_inc(w_wr_ptr_p1);
      else if (w_push_one) r_wr_ptr <= w_wr_ptr_p1;
      if (w_pop)           r_rd_ptr <= f_inc(r_rd_ptr);
      r_count <= r_count + CW'({w_push_two, w_push_one}) - CW'(w_pop);
    end
  end

`ifdef PREFETCH_FLUSH_COUNT_EN
  logic [15:0] r_flush_count;
  assign flush_count = r_flush_count;

  // Count every CS:IP update cycle, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset)            r_flush_count <= 16'h0000;
    else if (load_new_ip) r_flush_count <= r_flush_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_prefetch_sequencer.sv
// Bench for prefetch_sequencer: scenario tasks against a byte-queue reference model.
module tb_prefetch_sequencer;
  localparam int DEPTH = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cs = '0;
  logic [15:0] new_ip = '0;
  logic        load_new_ip = 1'b0;
  logic        mem_access;
  logic [18:0] mem_address;
  logic [1:0]  mem_bytesel;
  logic [15:0] mem_data = '0;
  logic        mem_ack = 1'b0;
  logic        fifo_rd_en = 1'b0;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
`ifdef PREFETCH_FLUSH_COUNT_EN
  logic [15:0] flush_count;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: fetch pointer, segment, FIFO contents, expected flush count.
  logic [15:0] m_ip;
  logic [15:0] m_cs;
  logic [7:0]  exp_q[$];
  int          exp_flush;

  prefetch_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cs(cs), .new_ip(new_ip), .load_new_ip(load_new_ip),
    .mem_access(mem_access), .mem_address(mem_address), .mem_bytesel(mem_bytesel),
    .mem_data(mem_data), .mem_ack(mem_ack), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty)
`ifdef PREFETCH_FLUSH_COUNT_EN
    , .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] exp_addr(input logic [15:0] c, input logic [15:0] ip);
    logic [19:0] p;
    p = {c, 4'h0} + {4'h0, ip};
    return p[19:1];
  endfunction

  function automatic logic [1:0] exp_bsel(input logic [15:0] ip);
    return ip[0] ? 2'b10 : 2'b11;
  endfunction

  function automatic int need_slots(input logic [15:0] ip);
    return ip[0] ? 1 : 2;
  endfunction

  // Apply reset, then load CS:IP in the first cycle out of reset. Starts and ends at a negedge.
  task automatic reset_load(input logic [15:0] c, input logic [15:0] ip);
    reset = 1'b1; load_new_ip = 1'b0; mem_ack = 1'b0; fifo_rd_en = 1'b0; cs = c;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; load_new_ip = 1'b1; new_ip = ip;
    @(negedge clk);
    load_new_ip = 1'b0;
    exp_q.delete(); m_ip = ip; m_cs = c; exp_flush = 1;
  endtask

  // Bus responder for one access: waits for a request, holds it for delay cycles, acks with random data.
  task automatic serve(input int delay, output bit ok, output logic [18:0] addr,
                       output logic [1:0] bsel, output bit held, output logic acc_after);
    int n;
    logic [15:0] d;
    n = 0; ok = 1'b0; held = 1'b1; addr = '0; bsel = '0; acc_after = 1'b1;
    while (mem_access !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (mem_access !== 1'b1) return;
    ok = 1'b1; addr = mem_address; bsel = mem_bytesel;
    repeat (delay) begin
      @(negedge clk);
      if (mem_access !== 1'b1 || mem_address !== addr || mem_bytesel !== bsel) held = 1'b0;
    end
    d = 16'($urandom); mem_data = d; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_data = 16'($urandom);
    acc_after = mem_access;
    if (m_ip[0]) begin
      exp_q.push_back(d[15:8]); m_ip = m_ip + 16'd1;
    end else begin
      exp_q.push_back(d[7:0]); exp_q.push_back(d[15:8]); m_ip = m_ip + 16'd2;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (mem_access !== 1'b0) begin errors++; $display("FAIL reset_access got=%b exp=0", mem_access); end
    checks++; if (mem_address !== 19'h0) begin errors++; $display("FAIL reset_address got=%h exp=0", mem_address); end
    checks++; if (mem_bytesel !== 2'b00) begin errors++; $display("FAIL reset_bytesel got=%b exp=00", mem_bytesel); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    checks++; if (fifo_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", fifo_rd_data); end
`ifdef PREFETCH_FLUSH_COUNT_EN
    checks++; if (flush_count !== 16'h0) begin errors++; $display("FAIL reset_flush_count got=%h exp=0", flush_count); end
`endif
  endtask

  task automatic test_fill;
    bit ok, held; logic [18:0] a, ea; logic [1:0] b, eb; logic acc; int quiet;
    reset_load(16'hF000, 16'hFFF0);
    checks++; if (mem_access !== 1'b0) begin errors++; $display("FAIL fill_idle_after_load got=%b exp=0", mem_access); end
    @(negedge clk);
    checks++; if (mem_access !== 1'b1 || mem_address !== 19'h7FFF8 || mem_bytesel !== 2'b11) begin
      errors++; $display("FAIL fill_first_req acc=%b addr=%h bsel=%b exp 1/7fff8/11", mem_access, mem_address, mem_bytesel);
    end
    while (DEPTH - exp_q.size() >= need_slots(m_ip)) begin
      ea = exp_addr(m_cs, m_ip); eb = exp_bsel(m_ip);
      serve(1, ok, a, b, held, acc);
      checks++; if (!ok || a !== ea || b !== eb || !held || acc !== 1'b0) begin
        errors++; $display("FAIL fill_req ok=%0d addr=%h bsel=%b held=%0d acc_after=%b exp addr=%h bsel=%b", ok, a, b, held, acc, ea, eb);
      end
      checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL fill_empty_after_ack got=%b exp=0", fifo_empty); end
    end
    quiet = 0;
    repeat (8) begin @(negedge clk); if (mem_access !== 1'b0) quiet++; end
    checks++; if (quiet != 0) begin errors++; $display("FAIL fill_full_no_req busy_cycles=%0d exp=0", quiet); end
    while (exp_q.size() > 0) begin
      checks++; if (fifo_empty !== 1'b0 || fifo_rd_data !== exp_q[0]) begin
        errors++; $display("FAIL fill_drain empty=%b data=%h exp=%h", fifo_empty, fifo_rd_data, exp_q[0]);
      end
      fifo_rd_en = 1'b1; @(negedge clk); fifo_rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL fill_drained_empty got=%b exp=1", fifo_empty); end
  endtask

  task automatic test_odd_start;
    bit ok, held; logic [18:0] a, ea; logic [1:0] b, eb; logic acc; int quiet;
    reset_load(16'h0000, 16'h0003);
    serve(0, ok, a, b, held, acc);
    checks++; if (!ok || a !== 19'h00001 || b !== 2'b10) begin
      errors++; $display("FAIL odd_first ok=%0d addr=%h bsel=%b exp 00001/10", ok, a, b);
    end
    checks++; if (fifo_rd_data !== exp_q[0] || exp_q.size() != 1) begin
      errors++; $display("FAIL odd_high_byte got=%h exp=%h", fifo_rd_data, exp_q[0]);
    end
    serve(0, ok, a, b, held, acc);
    checks++; if (!ok || a !== 19'h00002 || b !== 2'b11) begin
      errors++; $display("FAIL odd_second ok=%0d addr=%h bsel=%b exp 00002/11", ok, a, b);
    end
    ea = exp_addr(m_cs, m_ip); eb = exp_bsel(m_ip);
    serve(0, ok, a, b, held, acc);
    checks++; if (!ok || a !== ea || b !== eb) begin
      errors++; $display("FAIL odd_third ok=%0d addr=%h bsel=%b exp %h/%b", ok, a, b, ea, eb);
    end
    // Five bytes held, one slot free, even pointer: no fetch allowed.
    quiet = 0;
    repeat (6) begin @(negedge clk); if (mem_access !== 1'b0) quiet++; end
    checks++; if (quiet != 0) begin errors++; $display("FAIL odd_one_slot_no_req busy_cycles=%0d exp=0", quiet); end
    checks++; if (fifo_rd_data !== exp_q[0]) begin errors++; $display("FAIL odd_pop_head got=%h exp=%h", fifo_rd_data, exp_q[0]); end
    fifo_rd_en = 1'b1; @(negedge clk); fifo_rd_en = 1'b0;
    void'(exp_q.pop_front());
    ea = exp_addr(m_cs, m_ip); eb = exp_bsel(m_ip);
    serve(2, ok, a, b, held, acc);
    checks++; if (!ok || a !== ea || b !== eb || !held) begin
      errors++; $display("FAIL odd_resume ok=%0d addr=%h bsel=%b held=%0d exp %h/%b", ok, a, b, held, ea, eb);
    end
    while (exp_q.size() > 0) begin
      checks++; if (fifo_empty !== 1'b0 || fifo_rd_data !== exp_q[0]) begin
        errors++; $display("FAIL odd_drain empty=%b data=%h exp=%h", fifo_empty, fifo_rd_data, exp_q[0]);
      end
      fifo_rd_en = 1'b1; @(negedge clk); fifo_rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_ip_wrap;
    bit ok, held; logic [18:0] a; logic [1:0] b; logic acc;
    reset_load(16'h1000, 16'hFFFE);
    serve(1, ok, a, b, held, acc);
    checks++; if (!ok || {a, 1'b0} !== 20'h1FFFE || b !== 2'b11) begin
      errors++; $display("FAIL wrap_first ok=%0d phys=%h bsel=%b exp 1fffe/11", ok, {a, 1'b0}, b);
    end
    serve(1, ok, a, b, held, acc);
    checks++; if (!ok || {a, 1'b0} !== 20'h10000 || b !== 2'b11) begin
      errors++; $display("FAIL wrap_second ok=%0d phys=%h bsel=%b exp 10000/11", ok, {a, 1'b0}, b);
    end
  endtask

  task automatic test_flush_during_fetch;
    logic [15:0] c1, c2, ip1, ip2, ip3;
    logic [18:0] a0; int n, moved;
    c1 = 16'($urandom); c2 = 16'($urandom);
    ip1 = 16'($urandom); ip2 = 16'($urandom); ip3 = 16'($urandom);
    reset_load(c1, ip1);
    n = 0;
    while (mem_access !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    checks++; if (mem_access !== 1'b1 || mem_address !== exp_addr(c1, ip1)) begin
      errors++; $display("FAIL flush_first_req acc=%b addr=%h exp=%h", mem_access, mem_address, exp_addr(c1, ip1));
    end
    a0 = mem_address; moved = 0;
    load_new_ip = 1'b1; new_ip = ip2; cs = c2;
    @(negedge clk);
    if (mem_access !== 1'b1 || mem_address !== a0) moved++;
    load_new_ip = 1'b1; new_ip = ip3;
    @(negedge clk);
    if (mem_access !== 1'b1 || mem_address !== a0) moved++;
    load_new_ip = 1'b0;
    @(negedge clk);
    if (mem_access !== 1'b1 || mem_address !== a0) moved++;
    exp_flush += 2; m_ip = ip3; m_cs = c2;
    checks++; if (moved != 0) begin errors++; $display("FAIL flush_hold changed_cycles=%0d exp=0", moved); end
    mem_data = 16'($urandom); mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (fifo_empty !== 1'b1 || mem_access !== 1'b0) begin
      errors++; $display("FAIL flush_after_ack empty=%b acc=%b exp 1/0", fifo_empty, mem_access);
    end
    @(negedge clk);
    checks++; if (mem_access !== 1'b1 || mem_address !== exp_addr(m_cs, m_ip) || mem_bytesel !== exp_bsel(m_ip)) begin
      errors++; $display("FAIL flush_new_req acc=%b addr=%h bsel=%b exp 1/%h/%b", mem_access, mem_address, mem_bytesel, exp_addr(m_cs, m_ip), exp_bsel(m_ip));
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_still_empty got=%b exp=1", fifo_empty); end
`ifdef PREFETCH_FLUSH_COUNT_EN
    checks++; if (flush_count !== 16'(exp_flush)) begin errors++; $display("FAIL flush_count got=%0d exp=%0d", flush_count, exp_flush); end
`endif
  endtask

  task automatic test_load_with_ack;
    bit ok, held; logic [18:0] a; logic [1:0] b; logic acc; logic [15:0] ipb;
    reset_load(16'($urandom), 16'($urandom) & 16'hFFFE);
    serve(0, ok, a, b, held, acc);
    @(negedge clk);
    checks++; if (mem_access !== 1'b1 || mem_address !== exp_addr(m_cs, m_ip)) begin
      errors++; $display("FAIL coinc_second_req acc=%b addr=%h exp=%h", mem_access, mem_address, exp_addr(m_cs, m_ip));
    end
    ipb = 16'($urandom);
    mem_ack = 1'b1; mem_data = 16'($urandom); load_new_ip = 1'b1; new_ip = ipb; fifo_rd_en = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; load_new_ip = 1'b0; fifo_rd_en = 1'b0;
    exp_q.delete(); m_ip = ipb; exp_flush++;
    checks++; if (fifo_empty !== 1'b1 || mem_access !== 1'b0 || fifo_rd_data !== 8'h00) begin
      errors++; $display("FAIL coinc_flushed empty=%b acc=%b data=%h exp 1/0/00", fifo_empty, mem_access, fifo_rd_data);
    end
    @(negedge clk);
    checks++; if (mem_access !== 1'b1 || mem_address !== exp_addr(m_cs, m_ip) || mem_bytesel !== exp_bsel(m_ip)) begin
      errors++; $display("FAIL coinc_new_req acc=%b addr=%h bsel=%b exp 1/%h/%b", mem_access, mem_address, mem_bytesel, exp_addr(m_cs, m_ip), exp_bsel(m_ip));
    end
`ifdef PREFETCH_FLUSH_COUNT_EN
    checks++; if (flush_count !== 16'(exp_flush)) begin errors++; $display("FAIL coinc_flush_count got=%0d exp=%0d", flush_count, exp_flush); end
`endif
  endtask

  task automatic test_reset_mid_fetch;
    bit ok, held; logic [18:0] a; logic [1:0] b; logic acc;
    reset_load(16'($urandom), 16'($urandom));
    serve(0, ok, a, b, held, acc);
    @(negedge clk);
    checks++; if (mem_access !== 1'b1 || fifo_empty !== 1'b0) begin
      errors++; $display("FAIL rmid_setup acc=%b empty=%b exp 1/0", mem_access, fifo_empty);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_access !== 1'b0 || fifo_empty !== 1'b1 || mem_address !== 19'h0) begin
      errors++; $display("FAIL rmid_reset acc=%b empty=%b addr=%h exp 0/1/0", mem_access, fifo_empty, mem_address);
    end
    reset = 1'b0; m_ip = 16'h0000; exp_q.delete(); exp_flush = 0;
    @(negedge clk);
    checks++; if (mem_access !== 1'b1 || mem_address !== exp_addr(m_cs, m_ip) || mem_bytesel !== 2'b11) begin
      errors++; $display("FAIL rmid_restart acc=%b addr=%h bsel=%b exp 1/%h/11", mem_access, mem_address, mem_bytesel, exp_addr(m_cs, m_ip));
    end
`ifdef PREFETCH_FLUSH_COUNT_EN
    checks++; if (flush_count !== 16'h0) begin errors++; $display("FAIL rmid_flush_count got=%0d exp=0", flush_count); end
`endif
  endtask

  // Random ack delays and random pops; every request address and every head byte is checked.
  task automatic test_random_stream;
    bit pend; int wcnt; logic [18:0] pa; logic [1:0] pb; logic [15:0] d; bit rd;
    reset_load(16'($urandom), 16'($urandom));
    pend = 1'b0; wcnt = 0; pa = '0; pb = '0;
    for (int c = 0; c < 400; c++) begin
      if (pend) begin
        checks++; if (mem_access !== 1'b1 || mem_address !== pa || mem_bytesel !== pb) begin
          errors++; $display("FAIL rnd_hold acc=%b addr=%h bsel=%b exp 1/%h/%b", mem_access, mem_address, mem_bytesel, pa, pb);
        end
      end else if (mem_access === 1'b1) begin
        pa = exp_addr(m_cs, m_ip); pb = exp_bsel(m_ip);
        checks++; if (mem_address !== pa || mem_bytesel !== pb || (DEPTH - exp_q.size()) < need_slots(m_ip)) begin
          errors++; $display("FAIL rnd_req addr=%h bsel=%b exp %h/%b model_bytes=%0d", mem_address, mem_bytesel, pa, pb, exp_q.size());
        end
        pend = 1'b1; wcnt = $urandom_range(0, 3);
      end
      checks++; if (fifo_empty !== 1'(exp_q.size() == 0)) begin
        errors++; $display("FAIL rnd_empty got=%b model_bytes=%0d", fifo_empty, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        checks++; if (fifo_rd_data !== exp_q[0]) begin errors++; $display("FAIL rnd_data got=%h exp=%h", fifo_rd_data, exp_q[0]); end
      end
      rd = 1'($urandom_range(0, 1)); fifo_rd_en = rd;
      if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
      mem_ack = 1'b0;
      if (pend) begin
        if (wcnt == 0) begin
          d = 16'($urandom); mem_data = d; mem_ack = 1'b1; pend = 1'b0;
          if (m_ip[0]) begin exp_q.push_back(d[15:8]); m_ip = m_ip + 16'd1; end
          else begin exp_q.push_back(d[7:0]); exp_q.push_back(d[15:8]); m_ip = m_ip + 16'd2; end
        end else begin
          wcnt--;
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0; fifo_rd_en = 1'b0;
`ifdef PREFETCH_FLUSH_COUNT_EN
    checks++; if (flush_count !== 16'(exp_flush)) begin errors++; $display("FAIL rnd_flush_count got=%0d exp=%0d", flush_count, exp_flush); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_odd_start();
    test_ip_wrap();
    test_flush_during_fetch();
    test_load_with_ack();
    test_reset_mid_fetch();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
